// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state
// encodings, IR field positions, opcode classification and the strobe bundle.
package cpu_pkg;

    // IR field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer states, 4-bit encoded
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_T0     = 4'd1;
    localparam logic [3:0] S_T1     = 4'd2;
    localparam logic [3:0] S_T2     = 4'd3;
    localparam logic [3:0] S_T3     = 4'd4;
    localparam logic [3:0] S_T4     = 4'd5;
    localparam logic [3:0] S_T5     = 4'd6;
    localparam logic [3:0] S_T6     = 4'd7;
    localparam logic [3:0] S_HALTED = 4'd8;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Every datapath strobe the sequencer can drive
    typedef struct packed {
        logic       pc_out;
        logic       zlow_out;
        logic       zhigh_out;
        logic       mdr_out;
        logic       mar_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       zlow_in;
        logic       zhigh_in;
        logic       hi_in;
        logic       lo_in;
        logic       inc_pc;
        logic       read;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic [4:0] alu_op;
        logic       halted;
        logic       illegal_op;
    } strobes_t;

    function automatic op_class_t classify(input logic [4:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL, OP_NEG, OP_NOT: return CLS_ALU;
            OP_MUL, OP_DIV:                          return CLS_MULDIV;
            OP_NOP:                                  return CLS_NOP;
            OP_HALT:                                 return CLS_HALT;
            default:                                 return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/cs_decode.sv
// Combinational strobe decode: registered state plus IR opcode to the full
// strobe bundle. MemRdy is consulted only in T1 so the PC update and its bus
// transfer land on the single cycle the fetch completes.
module cs_decode
    import cpu_pkg::*;
(
    input  logic [3:0] state,
    input  logic [4:0] opcode,
    input  logic       mem_rdy,
    output strobes_t   strobes
);

    op_class_t cls;

    assign cls = classify(opcode);

    // Per-state strobe generation; anything not named stays low
    always_comb begin
        // NOTE: the all-zero default covers every path, so no latch can form.
        strobes = '0;
        case (state)
            S_T0: begin
                strobes.pc_out  = 1'b1;
                strobes.mar_in  = 1'b1;
                strobes.inc_pc  = 1'b1;
                strobes.zlow_in = 1'b1;
            end
            S_T1: begin
                strobes.read   = 1'b1;
                strobes.mdr_in = 1'b1;
                if (mem_rdy) begin
                    strobes.zlow_out = 1'b1;
                    strobes.pc_in    = 1'b1;
                end
            end
            S_T2: begin
                strobes.mdr_out = 1'b1;
                strobes.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_ALU, CLS_MULDIV: begin
                        strobes.grb   = 1'b1;
                        strobes.r_out = 1'b1;
                        strobes.y_in  = 1'b1;
                    end
                    CLS_ILLEGAL: strobes.illegal_op = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                strobes.grc      = 1'b1;
                strobes.r_out    = 1'b1;
                strobes.zlow_in  = 1'b1;
                strobes.zhigh_in = (cls == CLS_MULDIV);
                strobes.alu_op   = opcode;
            end
            S_T5: begin
                strobes.zlow_out = 1'b1;
                if (cls == CLS_MULDIV) begin
                    strobes.lo_in = 1'b1;
                end else begin
                    strobes.gra  = 1'b1;
                    strobes.r_in = 1'b1;
                end
            end
            S_T6: begin
                strobes.zhigh_out = 1'b1;
                strobes.hi_in     = 1'b1;
            end
            S_HALTED: strobes.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit sequencing the bus datapath through fetch and
// execute. Holds the state register and next-state logic; strobes come from
// cs_decode.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic        MemRdy,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  AluOp,
    output logic        Halted,
    output logic        IllegalOp
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [4:0] opcode;
    op_class_t  cls;
    strobes_t   strobes;

    // Register fields are decoded by the datapath, not here
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[RA_HI:0];

    assign opcode = IR[OPC_HI:OPC_LO];
    assign cls    = classify(opcode);

    // State register; Clear wins over every other input
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignment keeps all flops updating from pre-edge values.
        if (Clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; Run is only looked at where an instruction may start
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:   state_next = Run ? S_T0 : S_IDLE;
            S_T0:     state_next = S_T1;
            S_T1:     state_next = MemRdy ? S_T2 : S_T1;
            S_T2:     state_next = S_T3;
            S_T3: begin
                case (cls)
                    CLS_ALU, CLS_MULDIV: state_next = S_T4;
                    CLS_HALT:            state_next = S_HALTED;
                    default:             state_next = Run ? S_T0 : S_IDLE;
                endcase
            end
            S_T4:     state_next = S_T5;
            S_T5: begin
                if (cls == CLS_MULDIV) begin
                    state_next = S_T6;
                end else begin
                    state_next = Run ? S_T0 : S_IDLE;
                end
            end
            S_T6:     state_next = Run ? S_T0 : S_IDLE;
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_IDLE;
        endcase
    end

    cs_decode u_decode (
        .state   (state),
        .opcode  (opcode),
        .mem_rdy (MemRdy),
        .strobes (strobes)
    );

    assign PCout     = strobes.pc_out;
    assign Zlowout   = strobes.zlow_out;
    assign ZHighout  = strobes.zhigh_out;
    assign MDRout    = strobes.mdr_out;
    assign MARin     = strobes.mar_in;
    assign PCin      = strobes.pc_in;
    assign MDRin     = strobes.mdr_in;
    assign IRin      = strobes.ir_in;
    assign Yin       = strobes.y_in;
    assign ZLowIn    = strobes.zlow_in;
    assign ZHighIn   = strobes.zhigh_in;
    assign HIin      = strobes.hi_in;
    assign LOin      = strobes.lo_in;
    assign IncPC     = strobes.inc_pc;
    assign Read      = strobes.read;
    assign Gra       = strobes.gra;
    assign Grb       = strobes.grb;
    assign Grc       = strobes.grc;
    assign Rin       = strobes.r_in;
    assign Rout      = strobes.r_out;
    assign AluOp     = strobes.alu_op;
    assign Halted    = strobes.halted;
    assign IllegalOp = strobes.illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. An instruction-level model
// expands each instruction into its expected per-cycle strobe pattern; a
// compare process checks every cycle against it.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear, Run, MemRdy;
    logic [31:0] IR;
    logic        PCout, Zlowout, ZHighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
    logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  AluOp;
    logic        Halted, IllegalOp;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemRdy(MemRdy), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .AluOp(AluOp), .Halted(Halted),
        .IllegalOp(IllegalOp)
    );

    always #5 Clock = ~Clock;

    // Output vector layout used by the model
    localparam logic [26:0] M_PCOUT    = 27'd1 << 0;
    localparam logic [26:0] M_ZLOWOUT  = 27'd1 << 1;
    localparam logic [26:0] M_ZHIGHOUT = 27'd1 << 2;
    localparam logic [26:0] M_MDROUT   = 27'd1 << 3;
    localparam logic [26:0] M_MARIN    = 27'd1 << 4;
    localparam logic [26:0] M_PCIN     = 27'd1 << 5;
    localparam logic [26:0] M_MDRIN    = 27'd1 << 6;
    localparam logic [26:0] M_IRIN     = 27'd1 << 7;
    localparam logic [26:0] M_YIN      = 27'd1 << 8;
    localparam logic [26:0] M_ZLOWIN   = 27'd1 << 9;
    localparam logic [26:0] M_ZHIGHIN  = 27'd1 << 10;
    localparam logic [26:0] M_HIIN     = 27'd1 << 11;
    localparam logic [26:0] M_LOIN     = 27'd1 << 12;
    localparam logic [26:0] M_INCPC    = 27'd1 << 13;
    localparam logic [26:0] M_READ     = 27'd1 << 14;
    localparam logic [26:0] M_GRA      = 27'd1 << 15;
    localparam logic [26:0] M_GRB      = 27'd1 << 16;
    localparam logic [26:0] M_GRC      = 27'd1 << 17;
    localparam logic [26:0] M_RIN      = 27'd1 << 18;
    localparam logic [26:0] M_ROUT     = 27'd1 << 19;
    localparam logic [26:0] M_HALTED   = 27'd1 << 25;
    localparam logic [26:0] M_ILLEGAL  = 27'd1 << 26;
    localparam logic [26:0] M_BUS      = M_PCOUT | M_ZLOWOUT | M_ZHIGHOUT | M_MDROUT | M_ROUT;

    logic [26:0] act;
    assign act = {IllegalOp, Halted, AluOp, Rout, Rin, Grc, Grb, Gra, Read, IncPC,
                  LOin, HIin, ZHighIn, ZLowIn, Yin, IRin, MDRin, PCin, MARin,
                  MDRout, ZHighout, Zlowout, PCout};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;
    logic [26:0] exp_cur = '0;
    string       tag = "reset";
    int          cyc_cnt = 0;
    int          last_pc = 0;
    int          last_gap = 0;
    int          ill_cnt = 0;
    int          rin_cnt = 0;
    int          pcin_cnt = 0;
    logic [26:0] exp_seq[$];

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Instruction-level model: the strobe pattern of each cycle, in order
    task automatic build_seq(input logic [4:0] op, input int waits);
        bit is_alu, is_md;
        is_alu = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd17, 5'd18};
        is_md  = (op == 5'd15) || (op == 5'd16);
        exp_seq.delete();
        exp_seq.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN);
        for (int i = 0; i < waits; i++) exp_seq.push_back(M_READ | M_MDRIN);
        exp_seq.push_back(M_READ | M_MDRIN | M_ZLOWOUT | M_PCIN);
        exp_seq.push_back(M_MDROUT | M_IRIN);
        if (op == 5'd27 || op == 5'd26) begin
            exp_seq.push_back('0);
        end else if (!is_alu && !is_md) begin
            exp_seq.push_back(M_ILLEGAL);
        end else begin
            exp_seq.push_back(M_GRB | M_ROUT | M_YIN);
            exp_seq.push_back(M_GRC | M_ROUT | M_ZLOWIN | (is_md ? M_ZHIGHIN : 27'd0)
                              | (27'(op) << 20));
            if (is_md) begin
                exp_seq.push_back(M_ZLOWOUT | M_LOIN);
                exp_seq.push_back(M_ZHIGHOUT | M_HIIN);
            end else begin
                exp_seq.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
        end
    endtask

    // Per-cycle comparison against the model, plus event bookkeeping
    always @(negedge Clock) begin
        if (chk_en) begin
            cyc_cnt++;
            n_cmp++;
            if (act !== exp_cur) begin
                n_bad++;
                $display("FAIL %s (cycle %0d): outputs %h expected %h", tag, cyc_cnt, act, exp_cur);
            end
            n_cmp++;
            if ($countones(act & M_BUS) > 1) begin
                n_bad++;
                $display("FAIL bus_drivers %s (cycle %0d): %0d drivers expected at most 1",
                         tag, cyc_cnt, $countones(act & M_BUS));
            end
            if (PCout) begin
                last_gap = cyc_cnt - last_pc;
                last_pc  = cyc_cnt;
            end
            if (IllegalOp) ill_cnt++;
            if (Rin) rin_cnt++;
            if (PCin) pcin_cnt++;
        end
    end

    task automatic cyc(input logic run, input logic mem, input logic clr,
                       input logic [26:0] expv, input string name);
        Run     = run;
        MemRdy  = mem;
        Clear   = clr;
        exp_cur = expv;
        tag     = name;
        @(posedge Clock);
        #1;
    endtask

    // Drive one instruction from its T0; optionally assert Clear at cycle clr_at
    task automatic do_instr(input logic [31:0] ir, input int waits, input logic run,
                            input int clr_at, input string name);
        IR = ir;
        build_seq(ir[31:27], waits);
        for (int i = 0; i < exp_seq.size(); i++) begin
            cyc(run, !(i >= 1 && i <= waits), (i == clr_at), exp_seq[i],
                $sformatf("%s[%0d]", name, i));
            if (i == clr_at) break;
        end
    endtask

    initial begin
        int pc_before, rin_before;
        Clear = 1'b1; Run = 1'b0; MemRdy = 1'b1; IR = '0;
        @(posedge Clock);
        #1;
        chk_en = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, '0, "clear2_run_high");
        cyc(1'b0, 1'b1, 1'b0, '0, "idle_hold");
        cyc(1'b1, 1'b1, 1'b0, '0, "idle_go");

        // Pin the model with hand-derived facts
        build_seq(5'b00101, 0);
        check("model_and_len", exp_seq.size(), 6);
        check("model_and_t3_yin", int'(exp_seq[3][8]), 1);
        check("model_and_t4_aluop", int'(exp_seq[4][24:20]), 5);
        check("model_and_t5_rin", int'(exp_seq[5][18]), 1);
        build_seq(5'b01111, 0);
        check("model_mul_len", exp_seq.size(), 7);
        check("model_mul_t4_zhighin", int'(exp_seq[4][10]), 1);
        build_seq(5'b11010, 0);
        check("model_nop_len", exp_seq.size(), 4);

        do_instr(32'h2A1B8000, 0, 1'b1, -1, "and");
        pc_before = pcin_cnt;
        do_instr(32'h2A1B8000, 3, 1'b1, -1, "and_wait3");
        check("and_gap", last_gap, 6);
        check("pcin_once_per_fetch", pcin_cnt - pc_before, 1);
        do_instr(32'h78000000, 0, 1'b1, -1, "mul");
        check("and_wait3_gap", last_gap, 9);
        do_instr(32'hD0000000, 0, 1'b1, -1, "nop");
        check("mul_gap", last_gap, 7);
        check("illegal_none_yet", ill_cnt, 0);
        do_instr(32'hF8000000, 0, 1'b1, -1, "illegal");
        check("nop_gap", last_gap, 4);
        check("illegal_once", ill_cnt, 1);
        do_instr(32'h80000000, 0, 1'b1, -1, "div");
        check("illegal_gap", last_gap, 4);
        do_instr(32'h20000000, 1, 1'b0, -1, "sub_run_low");
        check("div_gap", last_gap, 7);
        cyc(1'b0, 1'b1, 1'b0, '0, "idle_after_sub");
        cyc(1'b1, 1'b1, 1'b0, '0, "idle_go_halt");

        do_instr(32'hD8000000, 0, 1'b1, -1, "halt");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, M_HALTED, "halted_hold");
        check("halted_level", int'(Halted), 1);
        cyc(1'b1, 1'b1, 1'b1, M_HALTED, "halted_clear");
        cyc(1'b1, 1'b1, 1'b0, '0, "idle_after_halt");
        check("halted_cleared", int'(Halted), 0);

        rin_before = rin_cnt;
        do_instr(32'h18000000, 0, 1'b1, 4, "add_clear_t4");
        cyc(1'b0, 1'b1, 1'b0, '0, "post_clear_idle");
        cyc(1'b0, 1'b1, 1'b0, '0, "post_clear_idle2");
        check("no_rin_after_clear", rin_cnt - rin_before, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
